btn_conditioner: RTL and testbench
==================================

# btn_conditioner

Conditions the raw, bouncing push-button inputs of the board before they reach `OTTER_Wrapper`'s `buttons` port and the MMIO button register. Per channel it:
- synchronises the raw input to `clk`;
- debounces it with a stable-run counter;
- emits a clean level plus one-cycle press and release pulses.

It sits directly upstream of the OTTER top-level. `btn_level[4]` is the source of the system reset request.

## Interface
Parameters:
- `N_BTNS`, 5, number of independent button channels.
- `DEBOUNCE_CYCLES`, 500000, consecutive stable cycles required to accept a new level. Range ≥1.
- `REPEAT_DELAY`, 25000000, cycles held before the first auto-repeat press. Used only with the repeat feature.
- `REPEAT_PERIOD`, 5000000, cycles between later auto-repeat presses. Used only with the repeat feature.

Ports:
- `clk`  in  1  system clock; all state is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `btn_raw`  in  `N_BTNS`  asynchronous raw button pins, active-high.
- `btn_level`  out  `N_BTNS`  debounced, registered button level.
- `btn_press`  out  `N_BTNS`  one-cycle pulse on an accepted 0→1 transition, and on each auto-repeat.
- `btn_release`  out  `N_BTNS`  one-cycle pulse on an accepted 1→0 transition.

## Operation
- Channels are fully independent. Each channel is one instance of the channel sub-module.
- **Synchroniser:** two flops, `sync1` then `sync2`. Call the synchronised value `s`.
- **Run counter:** width `$clog2(DEBOUNCE_CYCLES+1)`. It saturates and never wraps.
- **FSM states:** `LOW`, `WAIT_HIGH`, `HIGH`, `WAIT_LOW`.
- **`LOW`:**
  - `s`=1 and `DEBOUNCE_CYCLES`=1 → go to `HIGH`.
  - `s`=1 otherwise → go to `WAIT_HIGH` with cnt=1.
- **`WAIT_HIGH`:**
  - `s`=0 → go to `LOW` with cnt=0. The glitch is discarded and no pulse is emitted.
  - `s`=1 and cnt+1==`DEBOUNCE_CYCLES` → go to `HIGH`, set `btn_level`=1, pulse `btn_press`.
  - Otherwise cnt++.
- **`HIGH` and `WAIT_LOW`:** mirror images of the above. Commit to `LOW` sets `btn_level`=0 and pulses `btn_release`.
- `btn_press` and `btn_release` are registered. They are high for exactly one cycle and are never high together on one channel.
- **Held at reset release:** a button already pressed when `rst_n` deasserts is treated as a fresh 0→1 transition. It produces one `btn_press` after the normal debounce latency.

## Timing
- **Reset values:** while `rst_n`=0, `sync1`, `sync2`, cnt, `btn_level`, `btn_press` and `btn_release` are all 0, and the FSM is in `LOW`. Reset takes effect immediately, independent of `clk`.
- **Reset mid-debounce:** the pending transition is lost and no pulse is emitted.
- **Latency:**
  - `btn_raw` is first sampled high at edge t0 and then held.
  - `btn_level`, and `btn_press` for one cycle, become visible after edge t0+1+`DEBOUNCE_CYCLES`.
  - Release is symmetric.
- **Glitch rejection:** any raw pulse or gap shorter than `DEBOUNCE_CYCLES` synchronised cycles produces no output change.
- **Bounce restart:** bounce restarts the count from the beginning, not from the previous count value.

## Configuration
- Macro: `BTN_REPEAT_EN`.
- **Defined:**
  - In `HIGH`, a repeat counter starts at 0 on entry.
  - At count `REPEAT_DELAY`, the block pulses `btn_press` and reloads the counter.
  - After that it pulses every `REPEAT_PERIOD` cycles until the channel leaves `HIGH`.
  - Repeat pulses never coincide with the commit pulse. `btn_level` is unaffected.
  - Leaving `HIGH` (into `WAIT_LOW`) freezes the repeat counter. Returning to `HIGH` from `WAIT_LOW` resumes it without reset. Commit to `LOW` clears it.
- **Undefined:**
  - No repeat counter or logic is synthesised.
  - `btn_press` pulses only on commit.

## Structure
- **Package `btn_pkg`:** the FSM state enum `btn_state_t` (`LOW`, `WAIT_HIGH`, `HIGH`, `WAIT_LOW`) and default-parameter constants.
- **Sub-module `btn_debounce_ch`:** one channel, containing the synchroniser, run counter, FSM and optional repeat logic.
- **Top:** `btn_conditioner` is a generate loop over `N_BTNS` instances.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4. Repeat scenarios additionally use `REPEAT_DELAY`=10 and `REPEAT_PERIOD`=3.
- **Clean press:** `btn_raw[0]` goes 0→1 at edge t0 and is held → `btn_level[0]`=1 and a single `btn_press[0]` pulse after edge t0+5. Other channels stay 0.
- **Bounce:** raw pattern 1,0,1,1,0,1,1,1,1 → exactly one `btn_press`, with commit 5 edges after the final rising sample. `btn_level` never toggles before that.
- **Short glitch:** 3-cycle high pulse, then low → no `btn_press`, no `btn_release`, and `btn_level` stays 0.
- **Release:** after a press, raw goes low at edge t1 → `btn_level`=0 and one `btn_release` pulse after edge t1+5. `btn_press` does not fire.
- **Reset:**
  - Assert `rst_n`=0 mid-`WAIT_HIGH` → all outputs are 0 asynchronously.
  - Deassert with raw held high at edge t2 → `btn_press` after edge t2+5.
- **`BTN_REPEAT_EN`:** hold for 30 cycles after commit → presses at commit, commit+10, +13, +16, … +28. Stop on release.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and default constants for the push-button conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } btn_state_t;

  localparam int DEF_N_BTNS          = 5;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 5000000;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, stable-run debounce FSM, press/release pulses.
// Optional hold-to-repeat presses are built only when BTN_REPEAT_EN is defined.
import btn_pkg::*;

module btn_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("btn_debounce_ch: cycle parameters must be at least 1");
  end

  logic sync1_q, sync2_q;
  btn_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic level_q, level_d, press_q, press_d, release_q, release_d;

`ifdef BTN_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  logic [REP_W-1:0] rep_q, rep_d, rep_last;
  logic armed_q, armed_d;
`endif

  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      LOW: begin
        if (sync2_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = HIGH;
            level_d = 1'b1;
            press_d = 1'b1;
          end else begin
            state_d = WAIT_HIGH;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      WAIT_HIGH: begin
        if (!sync2_q) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HIGH: begin
        if (!sync2_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d   = LOW;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            state_d = WAIT_LOW;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      WAIT_LOW: begin
        if (sync2_q) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = LOW;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
      end
    endcase

`ifdef BTN_REPEAT_EN
    // Repeat timer only advances while settled in HIGH; it freezes through WAIT_LOW bounces.
    rep_d    = rep_q;
    armed_d  = armed_q;
    rep_last = armed_q ? REP_W'(REPEAT_PERIOD - 1) : REP_W'(REPEAT_DELAY - 1);
    if (state_q == HIGH && state_d == HIGH) begin
      if (rep_q == rep_last) begin
        press_d = 1'b1;
        rep_d   = '0;
        armed_d = 1'b1;
      end else begin
        rep_d = rep_q + REP_W'(1);
      end
    end else if (state_d == LOW) begin
      rep_d   = '0;
      armed_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= LOW;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

`ifdef BTN_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      rep_q   <= rep_d;
      armed_q <= armed_d;
    end
  end
`endif

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions N_BTNS raw push-buttons into clean levels plus press/release pulses.
// Define BTN_REPEAT_EN to add hold-to-repeat presses on every channel.
import btn_pkg::*;

module btn_conditioner #(
  parameter int N_BTNS          = DEF_N_BTNS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_BTNS-1:0] btn_raw,
  output logic [N_BTNS-1:0] btn_level,
  output logic [N_BTNS-1:0] btn_press,
  output logic [N_BTNS-1:0] btn_release
);

  for (genvar i = 0; i < N_BTNS; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_raw    (btn_raw[i]),
      .btn_level  (btn_level[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: directed scenarios plus random bouncing,
// all compared against a run-length reference model (repeat rules when BTN_REPEAT_EN).
module tb_btn_conditioner;

  localparam int NB  = 5;
  localparam int DB  = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level, btn_press, btn_release;

  int totalCount = 0;
  int badCount   = 0;
  bit scoreOn    = 1'b0;

  // Reference model: output level flips once the synchronised input has disagreed with it for DB edges
  logic [NB-1:0] mP1, mP2, mS, expLevel, expPress, expRel;
  int runLen[NB];
  int heldCnt[NB];
  bit armed[NB];
  int prevRun;

  btn_conditioner #(
    .N_BTNS(NB), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    if (obs !== exp) begin
      badCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mP1 = '0; mP2 = '0; expLevel = '0; expPress = '0; expRel = '0;
      for (int i = 0; i < NB; i++) begin
        runLen[i] = 0; heldCnt[i] = 0; armed[i] = 1'b0;
      end
    end else begin
      mS = mP2; mP2 = mP1; mP1 = btn_raw;
      expPress = '0; expRel = '0;
      for (int i = 0; i < NB; i++) begin
        prevRun = runLen[i];
        runLen[i] = (mS[i] != expLevel[i]) ? runLen[i] + 1 : 0;
        if (runLen[i] == DB) begin
          expLevel[i] = mS[i];
          runLen[i] = 0;
          heldCnt[i] = 0;
          armed[i] = 1'b0;
          if (mS[i]) expPress[i] = 1'b1;
          else       expRel[i]   = 1'b1;
        end
`ifdef BTN_REPEAT_EN
        else if (expLevel[i] && mS[i] && prevRun == 0) begin
          heldCnt[i]++;
          if (heldCnt[i] == (armed[i] ? RP : RD)) begin
            expPress[i] = 1'b1;
            heldCnt[i] = 0;
            armed[i] = 1'b1;
          end
        end
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (scoreOn) begin
      checkOutput("level", 32'(btn_level), 32'(expLevel));
      checkOutput("press", 32'(btn_press), 32'(expPress));
      checkOutput("release", 32'(btn_release), 32'(expRel));
    end
  end

  // Random bouncing: each channel toggles with a small probability per cycle
  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      for (int i = 0; i < NB; i++)
        if ($urandom_range(0, 11) == 0) btn_raw[i] = ~btn_raw[i];
    end
  endtask

  logic [8:0] bouncePat;

  initial begin
    rst_n = 1'b0;
    btn_raw = '0;
    bouncePat = 9'b111101101;
    #12;
    checkOutput("rstLevel", 32'(btn_level), 0);
    checkOutput("rstPress", 32'(btn_press), 0);
    checkOutput("rstRelease", 32'(btn_release), 0);
    @(negedge clk) rst_n = 1'b1;
    scoreOn = 1'b1;
    repeat (3) @(negedge clk);

    // Clean press on channel 0
    btn_raw[0] = 1'b1;
    repeat (5) @(posedge clk);
    #1 checkOutput("cleanEarly", 32'(btn_level[0]), 0);
    @(posedge clk);
    #1 checkOutput("cleanPress", 32'(btn_press[0]), 1);
    checkOutput("cleanLevel", 32'(btn_level[0]), 1);
    checkOutput("cleanOthers", 32'(btn_level[4:1]), 0);
    @(posedge clk);
    #1 checkOutput("cleanPulseEnd", 32'(btn_press[0]), 0);
`ifdef BTN_REPEAT_EN
    repeat (8) @(posedge clk);
    #1 checkOutput("repEarly", 32'(btn_press[0]), 0);
    @(posedge clk);
    #1 checkOutput("repFirst", 32'(btn_press[0]), 1);
    repeat (2) @(posedge clk);
    #1 checkOutput("repGap", 32'(btn_press[0]), 0);
    @(posedge clk);
    #1 checkOutput("repSecond", 32'(btn_press[0]), 1);
    repeat (14) @(posedge clk);
`else
    repeat (26) @(posedge clk);
`endif

    // Release on channel 0
    @(negedge clk) btn_raw[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1 checkOutput("relEarly", 32'(btn_level[0]), 1);
    @(posedge clk);
    #1 checkOutput("relPulse", 32'(btn_release[0]), 1);
    checkOutput("relLevel", 32'(btn_level[0]), 0);
    checkOutput("relNoPress", 32'(btn_press[0]), 0);

    // Bounce on channel 1
    for (int i = 0; i < 9; i++) begin
      @(negedge clk) btn_raw[1] = bouncePat[i];
    end
    @(posedge clk);
    #1 checkOutput("bounceWait3", 32'(btn_level[1]), 0);
    @(posedge clk);
    #1 checkOutput("bounceWait4", 32'(btn_level[1]), 0);
    @(posedge clk);
    #1 checkOutput("bouncePress", 32'(btn_press[1]), 1);

    // Short glitch on channel 2
    @(negedge clk) btn_raw[2] = 1'b1;
    repeat (3) @(negedge clk);
    btn_raw[2] = 1'b0;
    repeat (10) @(posedge clk);
    #1 checkOutput("glitchLevel", 32'(btn_level[2]), 0);

    // Reset mid-debounce on channel 3, then release reset with it held
    @(negedge clk) btn_raw[3] = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkOutput("asyncLevel", 32'(btn_level), 0);
    checkOutput("asyncPress", 32'(btn_press), 0);
    checkOutput("asyncRelease", 32'(btn_release), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 checkOutput("heldEarly", 32'(btn_press[3]), 0);
    @(posedge clk);
    #1 checkOutput("heldPress", 32'(btn_press[3]), 1);

    applyStimulus(3000);
    @(negedge clk) btn_raw = '0;
    repeat (40) @(negedge clk);
    checkOutput("finalLevel", 32'(btn_level), 0);

    scoreOn = 1'b0;
    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
